// File: rtl/spi_flash_sr_resp.sv
// SPI flash status-register responder.
// Emulates the status-register subset of a serial NOR flash: RDSR1/RDSR2
// reads, WREN/WRDI and WRSR1/WRSR2 writes, clocked entirely in the clk domain
// with the SPI pins oversampled (spi_clk must be at most clk/8).
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_clk, spi_cs_n SPI mode-0 clock and chip select (asynchronous)
//   spi_mosi          initiator-to-responder data (asynchronous)
//   spi_miso          responder-to-initiator data, 0 unless a read is active
//   sr1, sr2          current status registers (sr1[1]=WEL, sr1[0]=WIP=0)
//   wr_stb            one-clk pulse when a WRSR1/WRSR2 write commits
//
// state      | meaning
// ST_IDLE    | CS high, waiting for CS falling edge
// ST_CMD     | shifting in the opcode byte
// ST_RD      | streaming SR1/SR2 out on MISO, repeating every byte
// ST_WR_DATA | shifting in the WRSR data byte
// ST_WR_DONE | frame complete, command executes on CS rising edge
// ST_IGNORE  | frame discarded until CS rises
module spi_flash_sr_resp #(
    parameter logic [7:0] SR1_INIT  = 8'h00,
    parameter logic [7:0] SR2_INIT  = 8'h00,
    parameter logic [7:0] SR1_WMASK = 8'hFC,
    parameter logic [7:0] SR2_WMASK = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] sr1,
    output logic [7:0] sr2,
    output logic       wr_stb
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_RD, ST_WR_DATA, ST_WR_DONE, ST_IGNORE
    } state_t;

    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_RDSR2 = 8'h35;
    localparam logic [7:0] OP_WRSR1 = 8'h01;
    localparam logic [7:0] OP_WRSR2 = 8'h31;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    // WEL and WIP are never host-writable.
    localparam logic [7:0] SR1_M    = SR1_WMASK & 8'hFC;

    // Pin synchronizers plus one extra stage for edge detection.
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            sclk_meta_q <= spi_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] data_q, data_d;
    logic [7:0] rd_shift_q, rd_shift_d;
    logic       miso_q, miso_d;
    logic [7:0] sr1_q, sr1_d;
    logic [7:0] sr2_q, sr2_d;
    logic       wr_stb_q, wr_stb_d;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [7:0] shift_in, rd_src;

    // A CS falling edge only counts once CS has been seen high after reset
    // (after the synchronizer has flushed), so a CS held low through reset
    // cannot restart a frame mid-stream.
    assign cs_fall   = cs_prev_q & ~cs_sync_q & armed_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign shift_in  = {shift_q[6:0], mosi_sync_q};
    assign rd_src    = (opcode_q == OP_RDSR2) ? sr2_q : sr1_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        opcode_d   = opcode_q;
        data_d     = data_q;
        rd_shift_d = rd_shift_q;
        miso_d     = 1'b0;
        sr1_d      = sr1_q;
        sr2_d      = sr2_q;
        wr_stb_d   = 1'b0;
        settle_d   = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
        armed_d    = armed_q | ((settle_q == 2'd0) & cs_sync_q);

        if (cs_rise) begin
            state_d = ST_IDLE;
            if (state_q == ST_WR_DONE) begin
                case (opcode_q)
                    OP_WREN: sr1_d = sr1_q | 8'h02;
                    OP_WRDI: sr1_d = sr1_q & 8'hFC;
                    OP_WRSR1: begin
                        sr1_d    = ((sr1_q & ~SR1_M) | (data_q & SR1_M)) & 8'hFC;
                        wr_stb_d = 1'b1;
                    end
                    OP_WRSR2: begin
                        sr2_d    = (sr2_q & ~SR2_WMASK) | (data_q & SR2_WMASK);
                        sr1_d    = sr1_q & 8'hFC;
                        wr_stb_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        shift_d   = 8'h00;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            opcode_d = shift_in;
                            case (shift_in)
                                OP_RDSR1, OP_RDSR2: state_d = ST_RD;
                                OP_WRSR1, OP_WRSR2:
                                    state_d = sr1_q[1] ? ST_WR_DATA : ST_IGNORE;
                                OP_WREN, OP_WRDI:   state_d = ST_WR_DONE;
                                default:            state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_RD: begin
                    miso_d = miso_q;
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    // bit_cnt is 0 on the falling edge that starts each byte:
                    // that is where the register is snapshotted.
                    if (sclk_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            miso_d     = rd_src[7];
                            rd_shift_d = {rd_src[6:0], 1'b0};
                        end else begin
                            miso_d     = rd_shift_q[7];
                            rd_shift_d = {rd_shift_q[6:0], 1'b0};
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = shift_in;
                            state_d = ST_WR_DONE;
                        end
                    end
                end
                ST_WR_DONE: begin
                    if (sclk_rise) begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            opcode_q   <= 8'h00;
            data_q     <= 8'h00;
            rd_shift_q <= 8'h00;
            miso_q     <= 1'b0;
            sr1_q      <= SR1_INIT & 8'hFC;
            sr2_q      <= SR2_INIT;
            wr_stb_q   <= 1'b0;
            settle_q   <= 2'd2;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            opcode_q   <= opcode_d;
            data_q     <= data_d;
            rd_shift_q <= rd_shift_d;
            miso_q     <= miso_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            wr_stb_q   <= wr_stb_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

    assign spi_miso = miso_q;
    assign sr1      = sr1_q;
    assign sr2      = sr2_q;
    assign wr_stb   = wr_stb_q;

endmodule

// File: tb/tb_spi_flash_sr_resp.sv
// Bench for spi_flash_sr_resp: directed frames followed by random frames,
// each checked against a frame-level model of the status registers.
module tb_spi_flash_sr_resp;

    localparam logic [7:0] SR1_INIT  = 8'h00;
    localparam logic [7:0] SR2_INIT  = 8'h00;
    localparam logic [7:0] SR1_WMASK = 8'hFC;
    localparam logic [7:0] SR2_WMASK = 8'hFF;
    localparam int         HALF      = 40;   // spi_clk half period = 4 clk

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk, spi_cs_n, spi_mosi;
    logic       spi_miso;
    logic [7:0] sr1, sr2;
    logic       wr_stb;

    int tests  = 0;
    int failed = 0;
    int stb_cnt = 0;

    logic [7:0] sr1_m, sr2_m;

    spi_flash_sr_resp #(
        .SR1_INIT (SR1_INIT),
        .SR2_INIT (SR2_INIT),
        .SR1_WMASK(SR1_WMASK),
        .SR2_WMASK(SR2_WMASK)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi_clk (spi_clk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .sr1     (sr1),
        .sr2     (sr2),
        .wr_stb  (wr_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_stb === 1'b1) stb_cnt <= stb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        sr1_m = SR1_INIT & 8'hFC;
        sr2_m = SR2_INIT;
    endfunction

    // Effect of one complete CS-low frame of nbits bits, MSB of tx first.
    function automatic void model_frame(input logic [31:0] tx, input int nbits,
                                        output logic [31:0] exp_rx, output int exp_stb);
        logic [7:0] op, data, val, m1;
        op      = tx[31:24];
        data    = tx[23:16];
        m1      = SR1_WMASK & 8'hFC;
        exp_rx  = '0;
        exp_stb = 0;
        if (nbits >= 8) begin
            if (op == 8'h05 || op == 8'h35) begin
                val = (op == 8'h05) ? sr1_m : sr2_m;
                for (int i = 8; i < nbits; i++) exp_rx[31-i] = val[7 - ((i - 8) % 8)];
            end else if (op == 8'h06 && nbits == 8) begin
                sr1_m[1] = 1'b1;
            end else if (op == 8'h04 && nbits == 8) begin
                sr1_m[1] = 1'b0;
            end else if ((op == 8'h01 || op == 8'h31) && sr1_m[1] && nbits == 16) begin
                if (op == 8'h01) sr1_m = (sr1_m & ~m1) | (data & m1);
                else             sr2_m = (sr2_m & ~SR2_WMASK) | (data & SR2_WMASK);
                sr1_m[1] = 1'b0;
                exp_stb  = 1;
            end
        end
    endfunction

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #(2*HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        spi_cs_n = 1'b1;
        #(2*HALF);
    endtask

    task automatic send_bits(input logic [31:0] tx, input int first, input int nbits,
                             inout logic [31:0] rx);
        for (int i = first; i < first + nbits; i++) begin
            spi_mosi = tx[31-i];
            #(HALF);
            rx[31-i] = spi_miso;
            spi_clk = 1'b1;
            #(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] tx, input int nbits);
        logic [31:0] rx, exp_rx;
        int          exp_stb, stb0;
        model_frame(tx, nbits, exp_rx, exp_stb);
        rx   = '0;
        stb0 = stb_cnt;
        cs_low();
        send_bits(tx, 0, nbits, rx);
        cs_high();
        chk({tag, " miso"}, rx, exp_rx);
        chk({tag, " sr1"}, {24'h0, sr1}, {24'h0, sr1_m});
        chk({tag, " sr2"}, {24'h0, sr2}, {24'h0, sr2_m});
        chk({tag, " wr_stb"}, stb_cnt - stb0, exp_stb);
    endtask

    initial begin
        logic [31:0] rx;
        logic [7:0]  ops [7];
        int          nb, stb0;

        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("reset sr1", {24'h0, sr1}, {24'h0, SR1_INIT & 8'hFC});
        chk("reset sr2", {24'h0, sr2}, {24'h0, SR2_INIT});
        chk("reset miso", {31'h0, spi_miso}, 32'h0);
        chk("reset wr_stb", {31'h0, wr_stb}, 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post-reset stb", stb_cnt, 0);

        run_frame("rdsr1 x2", 32'h0500_0000, 24);
        run_frame("wren", 32'h0600_0000, 8);
        run_frame("rdsr1 wel", 32'h0500_0000, 16);
        run_frame("wrsr1 ff", 32'h01FF_0000, 16);
        run_frame("rdsr1 fc", 32'h0500_0000, 16);
        run_frame("wrsr1 no wel", 32'h01A5_0000, 16);
        run_frame("wren2", 32'h0600_0000, 8);
        run_frame("wrsr1 partial", 32'h01A5_0000, 12);
        run_frame("rdsr1 still wel", 32'h0500_0000, 16);
        run_frame("wrsr2 overlen", 32'h315A_0000, 24);
        run_frame("wrsr2 ok", 32'h315A_0000, 16);
        run_frame("rdsr2 5a", 32'h3500_0000, 32);
        run_frame("wrdi", 32'h0400_0000, 8);
        run_frame("partial op", 32'h0600_0000, 5);

        // Reset mid data byte with CS held low; the tail of the frame
        // after reset must not restart anything.
        run_frame("wren3", 32'h0600_0000, 8);
        rx   = '0;
        stb0 = stb_cnt;
        cs_low();
        send_bits(32'h31C3_0000, 0, 12, rx);
        rst_n = 1'b0;
        model_reset();
        #(2*HALF);
        chk("midrst sr1", {24'h0, sr1}, {24'h0, SR1_INIT & 8'hFC});
        chk("midrst sr2", {24'h0, sr2}, {24'h0, SR2_INIT});
        chk("midrst miso", {31'h0, spi_miso}, 32'h0);
        rst_n = 1'b1;
        #(2*HALF);
        send_bits(32'h31C3_0000, 12, 4, rx);
        cs_high();
        chk("midrst stb", stb_cnt - stb0, 0);
        chk("midrst sr2 after", {24'h0, sr2}, {24'h0, sr2_m});
        run_frame("rdsr2 init", 32'h3500_0000, 16);

        ops = '{8'h05, 8'h35, 8'h06, 8'h04, 8'h01, 8'h31, 8'h00};
        for (int k = 0; k < 30; k++) begin
            logic [31:0] tx;
            int          sel;
            sel = $urandom_range(0, 6);
            tx  = {(sel == 6) ? 8'($urandom) : ops[sel], 24'($urandom)};
            case ($urandom_range(0, 3))
                0:       nb = 8;
                1:       nb = 16;
                2:       nb = 24;
                default: nb = $urandom_range(1, 32);
            endcase
            run_frame($sformatf("rand%0d op=%h n=%0d", k, tx[31:24], nb), tx, nb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spi_flash_sr_resp.md
SPI_FLASH_SR_RESP -- requirements
Module: spi_flash_sr_resp

Interface
REQ-001 The block SHALL take parameter SR1_INIT, default 8'h00: reset value of status register 1.
REQ-002 The block SHALL take parameter SR2_INIT, default 8'h00: reset value of status register 2.
REQ-003 The block SHALL take parameter SR1_WMASK, default 8'hFC: host-writable bits of SR1. Bits 1:0 SHALL be treated as 0 regardless of this value.
REQ-004 The block SHALL take parameter SR2_WMASK, default 8'hFF: host-writable bits of SR2.
REQ-005 The block SHALL have port clk, input, 1 bit: single system clock. All logic is in this domain.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset. It is asynchronous and active-low.
REQ-007 The block SHALL have port spi_clk, input, 1 bit: SPI clock from the initiator, mode 0. It is asynchronous to clk.
REQ-008 The block SHALL have port spi_cs_n, input, 1 bit: chip select, active-low, asynchronous.
REQ-009 The block SHALL have port spi_mosi, input, 1 bit: initiator-to-responder data, asynchronous.
REQ-010 The block SHALL have port spi_miso, output, 1 bit: responder-to-initiator data.
REQ-011 The block SHALL have port sr1, output, 8 bits: current SR1. Bit 1 is WEL; bit 0 is WIP.
REQ-012 The block SHALL have port sr2, output, 8 bits: current SR2.
REQ-013 The block SHALL have port wr_stb, output, 1 bit: one-cycle pulse when a status write commits.

Function
REQ-014 The block SHALL pass spi_clk, spi_cs_n and spi_mosi each through a 2-FF synchronizer before use, and SHALL detect edges on the synchronized spi_clk.
REQ-015 The block SHALL operate correctly with an spi_clk frequency of at most clk/8.
REQ-016 The block SHALL sample MOSI on each synchronized spi_clk rising edge, MSB first, into an 8-bit shift register, with a 3-bit bit counter that wraps every 8 bits.
REQ-017 The FSM SHALL have states ST_IDLE, ST_CMD, ST_RD, ST_WR_DATA, ST_WR_DONE, ST_IGNORE.
REQ-018 ST_IDLE SHALL move to ST_CMD on a synchronized CS falling edge; the bit counter and shift register SHALL clear at that edge.
REQ-019 At the 8th rising edge in ST_CMD, the block SHALL latch the opcode, then take the transition for that opcode:
- 0x05 (RDSR1) or 0x35 (RDSR2) -> ST_RD.
- 0x01 (WRSR1) or 0x31 (WRSR2) with WEL=1 -> ST_WR_DATA.
- 0x06 (WREN) or 0x04 (WRDI) -> ST_WR_DONE.
- Any other opcode, or WRSR with WEL=0 -> ST_IGNORE.
REQ-020 ST_WR_DATA SHALL capture the 8 data bits and then move to ST_WR_DONE.
REQ-021 Any rising edge in ST_WR_DONE SHALL move to ST_IGNORE, so that over-length frames are discarded.
REQ-022 Every state SHALL return to ST_IDLE on a synchronized CS rising edge.
REQ-023 Commands SHALL execute only on a CS rising edge while in ST_WR_DONE:
- WREN sets sr1[1].
- WRDI clears sr1[1].
- WRSR1 applies sr1 <= (sr1 & ~M) | (data & M) with M = SR1_WMASK & 8'hFC, then clears sr1[1].
- WRSR2 applies sr2 <= (sr2 & ~SR2_WMASK) | (data & SR2_WMASK), then clears sr1[1].
REQ-024 wr_stb SHALL assert for exactly 1 clk, in the cycle sr1/sr2 update, for WRSR1/WRSR2 commits only (not for WREN or WRDI).
REQ-025 sr1[0] (WIP) SHALL be constant 0.
REQ-026 In ST_RD, the block SHALL shift the selected register out MSB first, changing spi_miso on each synchronized spi_clk falling edge.
REQ-027 In ST_RD, the first data bit SHALL be driven on the falling edge that follows the 8th opcode rising edge.
REQ-028 In ST_RD, the register value SHALL be reloaded every 8 bits, so reads repeat for as long as CS stays low.
REQ-029 spi_miso SHALL update no later than 4 clk cycles after a spi_clk falling edge at the pin.
REQ-030 spi_miso SHALL be 0 outside ST_RD.
REQ-031 If CS rises before the frame completes (partial opcode or partial data byte), the block SHALL return to ST_IDLE with no state change and no wr_stb.
REQ-032 Values returned by RDSR SHALL be snapshotted at the reload point, not tracked live.

Reset
REQ-033 Reset SHALL force the following, asynchronously on rst_n low:
- state = ST_IDLE.
- sr1 = SR1_INIT & 8'hFC.
- sr2 = SR2_INIT.
- wr_stb = 0, spi_miso = 0.
- Synchronizers = idle values: cs_n=1, sclk=0.
- Counters cleared.
REQ-034 When reset is released, the block SHALL NOT see a spurious CS edge or spi_clk edge, and no command SHALL execute.
REQ-035 If reset asserts mid-frame, the block SHALL abandon the transaction; the frame SHALL resume only after a new CS falling edge.

Verification
REQ-036 The bench SHALL cover: send 0x05 then read 16 bits -> MISO returns SR1_INIT&FC twice (8'h00 8'h00 with defaults).
REQ-037 The bench SHALL cover: send 0x06, CS high, then send 0x05 and read -> 8'h02; sr1 output = 8'h02.
REQ-038 The bench SHALL cover: 0x06; then 0x01 with data 0xFF -> sr1=8'hFC, wr_stb high for 1 clk; RDSR -> 8'hFC.
REQ-039 The bench SHALL cover: 0x01 0xA5 with WEL=0 -> sr1 unchanged, no wr_stb; with WEL=1 but CS raised after 12 bits -> unchanged, WEL stays 1.
REQ-040 The bench SHALL cover: 0x06, then 0x31 0x5A 0x00 (24 bits) -> over-length frame ignored, sr2 unchanged; repeat with 16 bits -> sr2=8'h5A, WEL cleared.
REQ-041 The bench SHALL cover: rst_n pulsed low mid-WRSR data byte -> all outputs at reset values; the next 0x35 read returns SR2_INIT.
